// File: rtl/sync_asym_width_fifo_pkg.sv
// Shared definitions for the asymmetric-width FIFO: lane-order encodings,
// a constant clog2 and the parameter-legality check used at elaboration.
`ifndef SYNC_ASYM_WIDTH_FIFO_PKG_SV
`define SYNC_ASYM_WIDTH_FIFO_PKG_SV

// Elaboration-time guard; expands to a generate block that stops elaboration on bad parameters.
`define SAWF_PARAM_CHECK(ok, msg) \
   if (!(ok)) begin : gParamCheck \
      $error(msg); \
   end

package sync_asym_width_fifo_pkg;

   typedef enum logic {
      LANE_MSB_FIRST = 1'b0,
      LANE_LSB_FIRST = 1'b1
   } lane_order_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic bit params_ok(input int unsigned ratio,
                                    input int unsigned depth,
                                    input int unsigned pfAssert,
                                    input int unsigned pfNegate,
                                    input int unsigned peAssert,
                                    input int unsigned peNegate,
                                    input int unsigned syncStage,
                                    input bit          laneOk);
      bit ratioOk;
      ratioOk = (ratio == 1) || (ratio == 2) || (ratio == 4) || (ratio == 8);
      return ratioOk && laneOk && (depth >= ratio) && ((depth % ratio) == 0) &&
             ((depth & (depth - 1)) == 0) && (pfNegate <= pfAssert) &&
             (pfAssert <= depth) && (peNegate >= peAssert) && (syncStage >= 1);
   endfunction

endpackage

`endif

// File: rtl/sync_asym_width_fifo_ram.sv
// Simple dual-port RAM with registered read and an optional second output
// stage; the read data only changes when a read actually completes.
module sdp_ram_wide
   import sync_asym_width_fifo_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int OUTPUT_REG = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic              kill_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd1_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd1_q <= '0;
      end else if (re_i) begin
         rd1_q <= mem[raddr_i];
      end
   end

   if (OUTPUT_REG != 0) begin : gOutReg
      logic              reD_q;
      logic [DATA_W-1:0] rd2_q;

      // The second stage is skipped when the pending read is killed by a flush.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            reD_q <= 1'b0;
            rd2_q <= '0;
         end else begin
            reD_q <= re_i;
            if (reD_q && !kill_i) begin
               rd2_q <= rd1_q;
            end
         end
      end

      assign rdata_o = rd2_q;
   end else begin : gOutDirect
      logic unusedKill;
      assign unusedKill = kill_i;
      assign rdata_o    = rd1_q;
   end

endmodule

// File: rtl/sync_asym_width_fifo.sv
// Single-clock FIFO packing RATIO narrow writes into one wide read word,
// with hysteresis flags, sticky error flags, flush and a reset-busy window.
module sync_asym_width_fifo
   import sync_asym_width_fifo_pkg::*;
#(
   parameter int    WR_DATA_WIDTH = 16,
   parameter int    RATIO         = 2,
   parameter int    DEPTH         = 512,
   parameter string LANE_ORDER    = "MSB_FIRST",
   parameter int    OUTPUT_REG    = 0,
   parameter int    SYNC_STAGE    = 2,
   parameter int    PF_ASSERT     = 384,
   parameter int    PF_NEGATE     = 320,
   parameter int    PE_ASSERT     = 8,
   parameter int    PE_NEGATE     = 16
) (
   input  logic                                     clk,
   input  logic                                     sys_rst_n,
   input  logic                                     flush_i,
   input  logic                                     wr_en_i,
   input  logic [WR_DATA_WIDTH-1:0]                 wdata,
   input  logic                                     rd_en_i,
   output logic [WR_DATA_WIDTH*RATIO-1:0]           rdata,
   output logic                                     rd_valid_o,
   output logic                                     full_o,
   output logic                                     empty_o,
   output logic                                     prog_full_o,
   output logic                                     prog_empty_o,
   output logic [clog2(DEPTH):0]                    wr_count_o,
   output logic                                     overflow_o,
   output logic                                     underflow_o,
   output logic                                     rst_busy_o
);

   localparam int W      = WR_DATA_WIDTH;
   localparam int RD_W   = WR_DATA_WIDTH * RATIO;
   localparam int ROWS   = DEPTH / RATIO;
   localparam int AW     = (ROWS > 1) ? int'(clog2(ROWS)) : 1;
   localparam int CNT_W  = int'(clog2(DEPTH)) + 1;
   localparam int LANE_W = (RATIO > 1) ? int'(clog2(RATIO)) : 1;

   localparam bit          LANE_IS_LSB = (LANE_ORDER == "LSB_FIRST");
   localparam bit          LANE_OK     = LANE_IS_LSB || (LANE_ORDER == "MSB_FIRST");
   localparam lane_order_e LANE_E      = LANE_IS_LSB ? LANE_LSB_FIRST : LANE_MSB_FIRST;

   localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  RATIO_C  = CNT_W'(RATIO);
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  PF_A_C   = CNT_W'(PF_ASSERT);
   localparam logic [CNT_W-1:0]  PF_N_C   = CNT_W'(PF_NEGATE);
   localparam logic [CNT_W-1:0]  PE_A_C   = CNT_W'(PE_ASSERT);
   localparam logic [CNT_W-1:0]  PE_N_C   = CNT_W'(PE_NEGATE);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   `SAWF_PARAM_CHECK(params_ok(RATIO, DEPTH, PF_ASSERT, PF_NEGATE, PE_ASSERT, PE_NEGATE,
                               SYNC_STAGE, LANE_OK),
                     "sync_asym_width_fifo: illegal parameter combination")

   logic [SYNC_STAGE-1:0] busySr_q;
   logic                  busy;
   logic                  blocked;
   logic                  wrAcc;
   logic                  rdAcc;
   logic                  lastLane;
   logic                  rowWrite;
   logic [LANE_W-1:0]     lanePos;
   logic [RD_W-1:0]       packMerged;

   logic [RD_W-1:0]   pack_q,     pack_d;
   logic [LANE_W-1:0] lane_q,     lane_d;
   logic [AW-1:0]     wrPtr_q,    wrPtr_d;
   logic [AW-1:0]     rdPtr_q,    rdPtr_d;
   logic [CNT_W-1:0]  count_q,    count_d;
   logic              full_q,     full_d;
   logic              empty_q,    empty_d;
   logic              progFull_q, progFull_d;
   logic              progEmpty_q, progEmpty_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              vld1_q;

   // Reset release is re-timed through a shift register of ones; requests are ignored until it drains.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         busySr_q <= '1;
      end else begin
         busySr_q <= busySr_q << 1;
      end
   end

   assign busy    = busySr_q[SYNC_STAGE-1];
   assign blocked = busy | flush_i;
   assign wrAcc   = wr_en_i & ~full_q & ~blocked;
   assign rdAcc   = rd_en_i & ~empty_q & ~blocked;

   always_comb begin
      lastLane   = (lane_q == LAST_LANE);
      lanePos    = (LANE_E == LANE_MSB_FIRST) ? (LAST_LANE - lane_q) : lane_q;
      packMerged = pack_q;
      for (int i = 0; i < RATIO; i++) begin
         if (lanePos == LANE_W'(i)) begin
            packMerged[i*W +: W] = wdata;
         end
      end
      rowWrite = wrAcc & lastLane;
   end

   always_comb begin
      pack_d      = pack_q;
      lane_d      = lane_q;
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (wr_en_i & full_q & ~blocked);
      underflow_d = underflow_q | (rd_en_i & empty_q & ~blocked);

      if (wrAcc) begin
         count_d = count_d + ONE_C;
         if (lastLane) begin
            pack_d  = '0;
            lane_d  = '0;
            wrPtr_d = wrPtr_q + AW'(1);
         end else begin
            pack_d  = packMerged;
            lane_d  = lane_q + LANE_W'(1);
         end
      end
      if (rdAcc) begin
         count_d = count_d - RATIO_C;
         rdPtr_d = rdPtr_q + AW'(1);
      end

      // A partial pack is always fewer than RATIO words, so count < RATIO means no complete row.
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d < RATIO_C);

      if (count_d >= PF_A_C) begin
         progFull_d = 1'b1;
      end else if (count_d < PF_N_C) begin
         progFull_d = 1'b0;
      end else begin
         progFull_d = progFull_q;
      end

      if (count_d <= PE_A_C) begin
         progEmpty_d = 1'b1;
      end else if (count_d > PE_N_C) begin
         progEmpty_d = 1'b0;
      end else begin
         progEmpty_d = progEmpty_q;
      end

      if (flush_i) begin
         pack_d      = '0;
         lane_d      = '0;
         wrPtr_d     = '0;
         rdPtr_d     = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         full_d      = 1'b0;
         empty_d     = 1'b1;
         progFull_d  = 1'b0;
         progEmpty_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pack_q      <= '0;
         lane_q      <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         progFull_q  <= 1'b0;
         progEmpty_q <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         vld1_q      <= 1'b0;
      end else begin
         pack_q      <= pack_d;
         lane_q      <= lane_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         progFull_q  <= progFull_d;
         progEmpty_q <= progEmpty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         vld1_q      <= rdAcc;
      end
   end

   if (OUTPUT_REG != 0) begin : gValidReg
      logic vld2_q;
      always_ff @(posedge clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            vld2_q <= 1'b0;
         end else begin
            vld2_q <= vld1_q & ~flush_i;
         end
      end
      assign rd_valid_o = vld2_q;
   end else begin : gValidDirect
      assign rd_valid_o = vld1_q;
   end

   sdp_ram_wide #(
      .DATA_W     (RD_W),
      .ADDR_W     (AW),
      .OUTPUT_REG (OUTPUT_REG)
   ) uRam (
      .clk_i   (clk),
      .rst_ni  (sys_rst_n),
      .we_i    (rowWrite),
      .waddr_i (wrPtr_q),
      .wdata_i (packMerged),
      .re_i    (rdAcc),
      .raddr_i (rdPtr_q),
      .kill_i  (flush_i),
      .rdata_o (rdata)
   );

   assign full_o       = full_q;
   assign empty_o      = empty_q;
   assign prog_full_o  = progFull_q;
   assign prog_empty_o = progEmpty_q;
   assign wr_count_o   = count_q;
   assign overflow_o   = overflow_q;
   assign underflow_o  = underflow_q;
   assign rst_busy_o   = busy;

endmodule

// File: tb/tb_sync_asym_width_fifo.sv
// Directed bench: dut1 uses the default MSB_FIRST/unregistered configuration,
// dut2 shares its stimulus with LSB_FIRST lanes and the extra output stage.
module tb_sync_asym_width_fifo;

   logic        clk = 1'b0;
   logic        sysRstN;
   logic        flush;
   logic        wrEn;
   logic        rdEn;
   logic [15:0] wdata;

   logic [31:0] rdata;
   logic        rdValid, full, empty, progFull, progEmpty, overflow, underflow, rstBusy;
   logic [9:0]  wrCount;

   logic [31:0] rdata2;
   logic        rdValid2;
   logic        unusedFull2, unusedEmpty2, unusedPf2, unusedPe2, unusedOvf2, unusedUnf2, unusedBusy2;
   logic [9:0]  unusedCount2;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   sync_asym_width_fifo dut (
      .clk(clk), .sys_rst_n(sysRstN), .flush_i(flush), .wr_en_i(wrEn), .wdata(wdata),
      .rd_en_i(rdEn), .rdata(rdata), .rd_valid_o(rdValid), .full_o(full), .empty_o(empty),
      .prog_full_o(progFull), .prog_empty_o(progEmpty), .wr_count_o(wrCount),
      .overflow_o(overflow), .underflow_o(underflow), .rst_busy_o(rstBusy)
   );

   sync_asym_width_fifo #(.LANE_ORDER("LSB_FIRST"), .OUTPUT_REG(1)) dut2 (
      .clk(clk), .sys_rst_n(sysRstN), .flush_i(flush), .wr_en_i(wrEn), .wdata(wdata),
      .rd_en_i(rdEn), .rdata(rdata2), .rd_valid_o(rdValid2), .full_o(unusedFull2),
      .empty_o(unusedEmpty2), .prog_full_o(unusedPf2), .prog_empty_o(unusedPe2),
      .wr_count_o(unusedCount2), .overflow_o(unusedOvf2), .underflow_o(unusedUnf2),
      .rst_busy_o(unusedBusy2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      wrEn  = 1'b0;
      rdEn  = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      sysRstN = 1'b0;
      wdata   = 16'h0000;
      setIdle();
      repeat (3) step();
      nCompared++;
      if ({rstBusy, empty, progEmpty, full, progFull, overflow, underflow, rdValid} !== 8'b1110_0000) begin
         nMismatched++;
         $display("[TB] FAIL reset_flags: got %b, expected 11100000",
                  {rstBusy, empty, progEmpty, full, progFull, overflow, underflow, rdValid});
      end
      nCompared++;
      if (wrCount !== 10'd0) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d, expected 0", wrCount); end
      nCompared++;
      if (rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h, expected 0", rdata); end

      sysRstN = 1'b1;
      wrEn    = 1'b1;
      rdEn    = 1'b1;
      wdata   = 16'h5555;
      nCompared++;
      if (rstBusy !== 1'b1) begin nMismatched++; $display("[TB] FAIL busy_at_release: got %b, expected 1", rstBusy); end
      step();
      nCompared++;
      if (rstBusy !== 1'b1) begin nMismatched++; $display("[TB] FAIL busy_cycle1: got %b, expected 1", rstBusy); end
      step();
      nCompared++;
      if (rstBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_cycle2: got %b, expected 0", rstBusy); end
      setIdle();
      nCompared++;
      if ({wrCount, overflow, underflow, empty} !== {10'd0, 1'b0, 1'b0, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL busy_ignores_req: got cnt=%0d ovf=%b unf=%b empty=%b, expected 0/0/0/1",
                  wrCount, overflow, underflow, empty);
      end
   endtask

   task automatic test_packing();
      wrEn = 1'b1; wdata = 16'h0001;
      step();
      nCompared++;
      if ({wrCount, empty} !== {10'd1, 1'b1}) begin
         nMismatched++; $display("[TB] FAIL pack_one_word: got cnt=%0d empty=%b, expected 1/1", wrCount, empty);
      end
      wdata = 16'h0002;
      step();
      nCompared++;
      if ({wrCount, empty} !== {10'd2, 1'b0}) begin
         nMismatched++; $display("[TB] FAIL pack_two_words: got cnt=%0d empty=%b, expected 2/0", wrCount, empty);
      end
      wrEn = 1'b0; rdEn = 1'b1;
      step();
      rdEn = 1'b0;
      nCompared++;
      if ({rdValid, rdata} !== {1'b1, 32'h0001_0002}) begin
         nMismatched++; $display("[TB] FAIL msb_first_read: got v=%b d=%h, expected 1/00010002", rdValid, rdata);
      end
      nCompared++;
      if ({wrCount, rdValid2} !== {10'd0, 1'b0}) begin
         nMismatched++; $display("[TB] FAIL pack_count_after_read: got cnt=%0d v2=%b, expected 0/0", wrCount, rdValid2);
      end
      step();
      nCompared++;
      if ({rdValid2, rdata2, rdValid} !== {1'b1, 32'h0002_0001, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL lsb_first_outreg_read: got v2=%b d2=%h v=%b, expected 1/00020001/0",
                  rdValid2, rdata2, rdValid);
      end
   endtask

   task automatic test_partial_row();
      wrEn = 1'b1; wdata = 16'h00AA;
      step();
      wrEn = 1'b0; rdEn = 1'b1;
      step();
      rdEn = 1'b0;
      nCompared++;
      if ({empty, rdValid, underflow, wrCount} !== {1'b1, 1'b0, 1'b1, 10'd1}) begin
         nMismatched++;
         $display("[TB] FAIL partial_row_read: got empty=%b v=%b unf=%b cnt=%0d, expected 1/0/1/1",
                  empty, rdValid, underflow, wrCount);
      end
      step();
      nCompared++;
      if (rdValid2 !== 1'b0) begin nMismatched++; $display("[TB] FAIL partial_row_v2: got %b, expected 0", rdValid2); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      nCompared++;
      if ({wrCount, underflow, empty} !== {10'd0, 1'b0, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL flush_partial: got cnt=%0d unf=%b empty=%b, expected 0/0/1", wrCount, underflow, empty);
      end
   endtask

   task automatic test_full_and_hysteresis();
      logic [31:0] expWord;
      logic [31:0] expWord2;
      for (int i = 0; i < 512; i++) begin
         wrEn  = 1'b1;
         wdata = 16'(i);
         step();
         if (i == 15 || i == 16) begin
            nCompared++;
            if (progEmpty !== (i == 15)) begin
               nMismatched++; $display("[TB] FAIL pe_rise_cnt%0d: got %b, expected %b", i + 1, progEmpty, (i == 15));
            end
         end
         if (i == 382 || i == 383) begin
            nCompared++;
            if (progFull !== (i == 383)) begin
               nMismatched++; $display("[TB] FAIL pf_rise_cnt%0d: got %b, expected %b", i + 1, progFull, (i == 383));
            end
         end
         if (i == 510 || i == 511) begin
            nCompared++;
            if (full !== (i == 511)) begin
               nMismatched++; $display("[TB] FAIL full_cnt%0d: got %b, expected %b", i + 1, full, (i == 511));
            end
         end
      end
      wdata = 16'hBEEF;
      step();
      wrEn = 1'b0;
      nCompared++;
      if ({overflow, wrCount, full} !== {1'b1, 10'd512, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL overflow_write: got ovf=%b cnt=%0d full=%b, expected 1/512/1", overflow, wrCount, full);
      end

      for (int k = 0; k < 256; k++) begin
         rdEn = 1'b1;
         step();
         expWord = {16'(2 * k), 16'(2 * k + 1)};
         nCompared++;
         if ({rdValid, rdata} !== {1'b1, expWord}) begin
            nMismatched++; $display("[TB] FAIL drain_read%0d: got v=%b d=%h, expected 1/%h", k, rdValid, rdata, expWord);
         end
         if (k >= 1) begin
            expWord2 = {16'(2 * k - 1), 16'(2 * k - 2)};
            nCompared++;
            if ({rdValid2, rdata2} !== {1'b1, expWord2}) begin
               nMismatched++;
               $display("[TB] FAIL drain2_read%0d: got v=%b d=%h, expected 1/%h", k - 1, rdValid2, rdata2, expWord2);
            end
         end
         if (k == 0) begin
            nCompared++;
            if (full !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_release: got %b, expected 0", full); end
         end
         if (k == 94 || k == 95 || k == 96) begin
            nCompared++;
            if (progFull !== (k != 96)) begin
               nMismatched++; $display("[TB] FAIL pf_fall_cnt%0d: got %b, expected %b", 510 - 2 * k, progFull, (k != 96));
            end
         end
         if (k == 247 || k == 250 || k == 251) begin
            nCompared++;
            if (progEmpty !== (k == 251)) begin
               nMismatched++; $display("[TB] FAIL pe_fall_cnt%0d: got %b, expected %b", 510 - 2 * k, progEmpty, (k == 251));
            end
         end
         if (k == 254 || k == 255) begin
            nCompared++;
            if ({empty, wrCount} !== {(k == 255), 10'(510 - 2 * k)}) begin
               nMismatched++;
               $display("[TB] FAIL drain_empty_cnt%0d: got empty=%b cnt=%0d", 510 - 2 * k, empty, wrCount);
            end
         end
      end
      rdEn = 1'b0;
      step();
      nCompared++;
      if ({rdValid2, rdata2, rdValid, overflow} !== {1'b1, 32'h01FF_01FE, 1'b0, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL drain_tail: got v2=%b d2=%h v=%b ovf=%b, expected 1/01ff01fe/0/1",
                  rdValid2, rdata2, rdValid, overflow);
      end
   endtask

   task automatic test_flush();
      rdEn = 1'b1;
      step();
      rdEn = 1'b0;
      nCompared++;
      if ({underflow, overflow, rdValid} !== 3'b110) begin
         nMismatched++; $display("[TB] FAIL sticky_pre_flush: got unf=%b ovf=%b v=%b, expected 1/1/0", underflow, overflow, rdValid);
      end
      for (int i = 0; i < 4; i++) begin
         wrEn  = 1'b1;
         wdata = 16'h0A0A + 16'(i) * 16'h0101;
         step();
      end
      wrEn = 1'b0; rdEn = 1'b1;
      step();
      nCompared++;
      if ({rdValid, rdata, wrCount} !== {1'b1, 32'h0A0A_0B0B, 10'd2}) begin
         nMismatched++;
         $display("[TB] FAIL pre_flush_read: got v=%b d=%h cnt=%0d, expected 1/0a0a0b0b/2", rdValid, rdata, wrCount);
      end
      flush = 1'b1;
      step();
      flush = 1'b0; rdEn = 1'b0;
      nCompared++;
      if ({rdValid, rdValid2, wrCount, empty, progEmpty, overflow, underflow} !== {1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL flush_state: got v=%b v2=%b cnt=%0d empty=%b pe=%b ovf=%b unf=%b",
                  rdValid, rdValid2, wrCount, empty, progEmpty, overflow, underflow);
      end
      nCompared++;
      if ({rdata, rdata2} !== {32'h0A0A_0B0B, 32'h01FF_01FE}) begin
         nMismatched++; $display("[TB] FAIL flush_rdata_hold: got %h/%h, expected 0a0a0b0b/01ff01fe", rdata, rdata2);
      end
      step();
      nCompared++;
      if ({rdValid, rdValid2} !== 2'b00) begin
         nMismatched++; $display("[TB] FAIL flush_no_late_valid: got v=%b v2=%b, expected 0/0", rdValid, rdValid2);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] expWord;
      int          nRead;
      for (int i = 0; i < 10; i++) begin
         wrEn  = 1'b1;
         wdata = 16'h0100 + 16'(i);
         step();
      end
      nRead = 0;
      for (int j = 0; j < 8; j++) begin
         wrEn  = 1'b1;
         wdata = 16'h010A + 16'(j);
         rdEn  = (j % 2 == 1);
         step();
         nCompared++;
         if (wrCount !== ((j % 2 == 1) ? 10'd10 : 10'd11)) begin
            nMismatched++; $display("[TB] FAIL b2b_count_cycle%0d: got %0d", j, wrCount);
         end
         if (j % 2 == 1) begin
            expWord = {16'h0100 + 16'(2 * nRead), 16'h0101 + 16'(2 * nRead)};
            nCompared++;
            if ({rdValid, rdata} !== {1'b1, expWord}) begin
               nMismatched++; $display("[TB] FAIL b2b_read%0d: got v=%b d=%h, expected 1/%h", nRead, rdValid, rdata, expWord);
            end
            nRead++;
         end else begin
            nCompared++;
            if (rdValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_idle_valid%0d: got %b, expected 0", j, rdValid); end
         end
      end
      setIdle();
   endtask

   task automatic test_async_reset();
      step();
      sysRstN = 1'b0;
      #2;
      nCompared++;
      if ({wrCount, rstBusy, empty, progEmpty, rdValid, rdata} !== {10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0}) begin
         nMismatched++;
         $display("[TB] FAIL async_reset: got cnt=%0d busy=%b empty=%b pe=%b v=%b d=%h",
                  wrCount, rstBusy, empty, progEmpty, rdValid, rdata);
      end
      step();
      sysRstN = 1'b1;
      step();
      nCompared++;
      if (rstBusy !== 1'b1) begin nMismatched++; $display("[TB] FAIL async_busy1: got %b, expected 1", rstBusy); end
      step();
      nCompared++;
      if (rstBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_busy2: got %b, expected 0", rstBusy); end
   endtask

   initial begin
      test_reset();
      test_packing();
      test_partial_row();
      test_full_and_hysteresis();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
